// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the single UART transmit byte channel between NUM_REQ byte sources.
//   Round-robin grant with message lock: the owner keeps the channel until it
//   hands over a byte flagged last, or leaves its valid low for IDLE_TIMEOUT
//   cycles (IDLE_TIMEOUT = 0 disables the forced release).
//
//   Ports
//     clk, rst_n           system clock, asynchronous active-low reset
//     req_valid/data/last  per-requester byte stream, requester i on data[8*i+7:8*i]
//     req_ready            per-requester accept (only the owner ever sees ready)
//     tx_data_valid/tx_data/tx_data_ready
//                          byte channel towards the uart block
//     grant_id             current owner; holds the previous owner while idle
//     busy                 channel locked to an owner
//     timeout_evt          one-cycle pulse when a lock is force-released
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | no owner; a pending request is granted here (1-cycle latency)
//   S_LOCKED | owner_q forwards its bytes until a last byte or idle timeout

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_data_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_data_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_evt
);

    localparam int IDW = $clog2(NUM_REQ);
    // A zero timeout still needs a 1-bit counter to keep the vector legal.
    localparam int CW  = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  CNT_LIM    = (IDLE_TIMEOUT > 0) ? CW'(IDLE_TIMEOUT - 1) : '0;
    localparam logic [CW-1:0]  CNT_MAX    = '1;
    localparam logic [IDW-1:0] OWNER_LAST = IDW'(NUM_REQ - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] owner_q;
    logic [IDW-1:0] last_owner_q;
    logic [CW-1:0]  idle_cnt_q;
    logic           timeout_evt_q;

    logic           locked;
    logic           own_valid;
    logic           own_last;
    logic           handshake;
    logic           timeout_hit;
    logic [IDW-1:0] next_owner_d;

    assign locked      = (state_q == S_LOCKED);
    assign own_valid   = locked & req_valid[owner_q];
    assign own_last    = req_last[owner_q];
    assign handshake   = own_valid & tx_data_ready;
    // Only owner-idle time counts; a stalled uart (valid=1, ready=0) never does.
    assign timeout_hit = (IDLE_TIMEOUT != 0) && locked && !req_valid[owner_q]
                         && (idle_cnt_q == CNT_LIM);

    // tx_data_valid depends on state and req_valid only, never on tx_data_ready.
    assign tx_data_valid = own_valid;
    assign tx_data       = locked ? req_data[8*int'(owner_q) +: 8] : 8'h00;
    assign busy          = locked;
    assign grant_id      = owner_q;
    assign timeout_evt   = timeout_evt_q;

    always_comb begin
        req_ready = '0;
        if (locked) begin
            req_ready[owner_q] = tx_data_ready;
        end
    end

    // Round-robin pick: first pending requester after the previous owner.
    always_comb begin
        int   idx;
        logic found;
        next_owner_d = last_owner_q;
        found        = 1'b0;
        idx          = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_owner_q) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found        = 1'b1;
                next_owner_d = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            owner_q       <= '0;
            last_owner_q  <= OWNER_LAST;
            idle_cnt_q    <= '0;
            timeout_evt_q <= 1'b0;
        end else begin
            timeout_evt_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|req_valid) begin
                        owner_q    <= next_owner_d;
                        idle_cnt_q <= '0;
                        state_q    <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (handshake && own_last) begin
                        state_q      <= S_IDLE;
                        last_owner_q <= owner_q;
                        idle_cnt_q   <= '0;
                    end else if (timeout_hit) begin
                        state_q       <= S_IDLE;
                        last_owner_q  <= owner_q;
                        idle_cnt_q    <= '0;
                        timeout_evt_q <= 1'b1;
                    end else if (own_valid) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != CNT_MAX) begin
                        idle_cnt_q <= idle_cnt_q + CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (long and short idle timeout) share
// one set of requester/uart stimulus; sel_b chooses which one the tests observe.
module tb_uart_tx_arbiter;

    localparam int NR   = 2;
    localparam int TO_B = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_last;
    logic [8*NR-1:0] req_data;
    logic            tx_data_ready;

    logic [NR-1:0] rdy_a, rdy_b, m_rdy;
    logic          txv_a, txv_b, m_txv;
    logic [7:0]    txd_a, txd_b, m_txd;
    logic          gid_a, gid_b, m_gid;
    logic          busy_a, busy_b, m_busy;
    logic          evt_a, evt_b, m_evt;
    bit            sel_b = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NR), .IDLE_TIMEOUT(1024)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rdy_a), .tx_data_valid(txv_a),
        .tx_data(txd_a), .tx_data_ready(tx_data_ready), .grant_id(gid_a),
        .busy(busy_a), .timeout_evt(evt_a));

    uart_tx_arbiter #(.NUM_REQ(NR), .IDLE_TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(rdy_b), .tx_data_valid(txv_b),
        .tx_data(txd_b), .tx_data_ready(tx_data_ready), .grant_id(gid_b),
        .busy(busy_b), .timeout_evt(evt_b));

    assign m_rdy  = sel_b ? rdy_b  : rdy_a;
    assign m_txv  = sel_b ? txv_b  : txv_a;
    assign m_txd  = sel_b ? txd_b  : txd_a;
    assign m_gid  = sel_b ? gid_b  : gid_a;
    assign m_busy = sel_b ? busy_b : busy_a;
    assign m_evt  = sel_b ? evt_b  : evt_a;

    int checks   = 0;
    int failures = 0;

    // Requester byte queues: {gap[15:0], last, data}; gap = low cycles before the byte.
    logic [24:0] rq0[$];
    logic [24:0] rq1[$];
    int          wcnt [NR];
    bit          hs [NR];
    int          rdy_pct;
    int          stepn;
    int          inv_bad;
    logic        s_busy, s_txv, s_evt;
    logic [7:0]  s_txd;
    logic [NR-1:0] s_rdy;

    int         acc_src[$];
    logic [7:0] acc_dat[$];
    bit         acc_last[$];
    int         acc_step[$];
    logic       acc_gid[$];
    bit         acc_oth[$];
    int         evt_steps[$];
    bit         busy_log[$];

    // Requester rule: a pending byte stays valid and stable until accepted.
    logic [NR-1:0]   pv, pr, pl;
    logic [8*NR-1:0] pd;
    logic            prst;
    always @(negedge clk) begin
        if (rst_n && prst) begin
            for (int i = 0; i < NR; i++) begin
                if (pv[i] && !pr[i]) begin
                    assert (req_valid[i] && req_data[8*i +: 8] == pd[8*i +: 8] && req_last[i] == pl[i])
                        else $error("requester %0d dropped or changed a pending byte", i);
                end
            end
        end
        pv   <= req_valid;
        pr   <= m_rdy;
        pd   <= req_data;
        pl   <= req_last;
        prst <= rst_n;
    end

    task automatic push(input int i, input int gap, input bit last, input logic [7:0] d);
        if (i == 0) rq0.push_back({16'(gap), last, d});
        else        rq1.push_back({16'(gap), last, d});
    endtask

    // One clock cycle: drive at posedge+1, sample at negedge, end at next posedge+1.
    task automatic step();
        logic [24:0] h;
        bit          ne;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) begin
                if (i == 0) void'(rq0.pop_front());
                else        void'(rq1.pop_front());
                wcnt[i] = 0;
            end
            ne = (i == 0) ? (rq0.size() > 0) : (rq1.size() > 0);
            h  = 25'd0;
            if (ne) h = (i == 0) ? rq0[0] : rq1[0];
            if (ne && wcnt[i] >= int'(h[24:9])) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i]        = h[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
                wcnt[i]            = ne ? wcnt[i] + 1 : 0;
            end
        end
        if (rdy_pct >= 100)    tx_data_ready = 1'b1;
        else if (rdy_pct <= 0) tx_data_ready = 1'b0;
        else                   tx_data_ready = (int'($urandom_range(99)) < rdy_pct);

        @(negedge clk);
        s_busy = m_busy;
        s_txv  = m_txv;
        s_txd  = m_txd;
        s_evt  = m_evt;
        s_rdy  = m_rdy;
        if (!m_busy && (m_txv || m_rdy != '0)) inv_bad++;
        if ($countones(m_rdy) > 1) inv_bad++;
        if (m_busy && ((m_rdy & ~(NR'(1) << m_gid)) != '0)) inv_bad++;
        if ((|(req_valid & m_rdy)) != (m_txv && tx_data_ready)) inv_bad++;
        for (int i = 0; i < NR; i++) begin
            hs[i] = req_valid[i] && m_rdy[i];
            if (hs[i]) begin
                acc_src.push_back(i);
                acc_dat.push_back(m_txd);
                acc_last.push_back(req_last[i]);
                acc_step.push_back(stepn);
                acc_gid.push_back(m_gid);
                acc_oth.push_back(req_valid[NR-1-i]);
            end
        end
        if (m_evt) evt_steps.push_back(stepn);
        busy_log.push_back(m_busy);
        @(posedge clk);
        #1;
        stepn++;
    endtask

    task automatic run_until(input int n, input int bound, output bit ok);
        int k;
        k = 0;
        while (acc_src.size() < n && k < bound) begin
            step();
            k++;
        end
        ok = (acc_src.size() >= n);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        tx_data_ready = 1'b0;
        rq0.delete(); rq1.delete();
        acc_src.delete(); acc_dat.delete(); acc_last.delete(); acc_step.delete();
        acc_gid.delete(); acc_oth.delete(); evt_steps.delete(); busy_log.delete();
        for (int i = 0; i < NR; i++) begin
            hs[i]   = 1'b0;
            wcnt[i] = 0;
        end
        rdy_pct = 100;
        inv_bad = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        stepn = 0;
    endtask

    task automatic test_reset();
        sel_b = 1'b0;
        do_reset();
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got a=%b b=%b expected 0", busy_a, busy_b);
        end
        checks++;
        if (txv_a !== 1'b0 || txv_b !== 1'b0 || txd_a !== 8'h00) begin
            failures++; $display("FAIL reset_tx: got valid a=%b b=%b data=%h expected 0", txv_a, txv_b, txd_a);
        end
        checks++;
        if (rdy_a !== 2'b00 || rdy_b !== 2'b00) begin
            failures++; $display("FAIL reset_ready: got a=%b b=%b expected 00", rdy_a, rdy_b);
        end
        checks++;
        if (gid_a !== 1'b0 || evt_a !== 1'b0 || evt_b !== 1'b0) begin
            failures++; $display("FAIL reset_gid_evt: got gid=%b evt a=%b b=%b expected 0", gid_a, evt_a, evt_b);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rdy_pct = 0;
        push(0, 0, 1'b0, 8'hA1);
        push(0, 0, 1'b0, 8'hA2);
        push(0, 0, 1'b1, 8'hA3);
        repeat (3) step();
        tx_data_ready = 1'b1;
        #1;
        checks++;
        if (busy_a !== 1'b1 || rdy_a[0] !== 1'b1 || txv_a !== 1'b1) begin
            failures++; $display("FAIL mid_pre_locked: got busy=%b rdy=%b txv=%b expected 1", busy_a, rdy_a[0], txv_a);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || txv_a !== 1'b0 || rdy_a !== 2'b00) begin
            failures++; $display("FAIL mid_reset_clear: got busy=%b txv=%b rdy=%b expected 0", busy_a, txv_a, rdy_a);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit ok;
        do_reset();
        push(0, 0, 1'b0, 8'h48);
        push(0, 0, 1'b1, 8'h69);
        run_until(2, 20, ok);
        step();
        checks++;
        if (!ok || acc_src.size() != 2) begin
            failures++; $display("FAIL single_count: got %0d bytes expected 2", acc_src.size());
        end else begin
            checks++;
            if (acc_dat[0] !== 8'h48 || acc_dat[1] !== 8'h69 || acc_src[0] != 0 || acc_src[1] != 0) begin
                failures++; $display("FAIL single_data: got %h,%h expected 48,69", acc_dat[0], acc_dat[1]);
            end
            checks++;
            if (acc_step[0] != 1 || acc_step[1] != 2) begin
                failures++; $display("FAIL single_timing: got steps %0d,%0d expected 1,2", acc_step[0], acc_step[1]);
            end
            checks++;
            if (busy_log[0] !== 1'b0 || busy_log[2] !== 1'b1 || busy_log[3] !== 1'b0) begin
                failures++; $display("FAIL single_busy: got %b%b%b expected 010", busy_log[0], busy_log[2], busy_log[3]);
            end
        end
    endtask

    task automatic test_contention();
        int         lens [2][2];
        logic [7:0] bpool [2][$];
        int         e_src[$];
        logic [7:0] e_dat[$];
        int         e_step[$];
        int         nxt [2];
        int         pos [2];
        int         turn, t, s, n;
        bit         ok;
        do_reset();
        lens = '{'{2, 1}, '{2, 1}};
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < 2; m++) begin
                for (int j = 0; j < lens[r][m]; j++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    bpool[r].push_back(d);
                    push(r, 0, j == lens[r][m] - 1, d);
                end
            end
        end
        // Model: both always pending -> whole messages alternate, starting with 0,
        // first byte one cycle after the grant, one idle cycle between messages.
        nxt = '{0, 0}; pos = '{0, 0}; turn = 0; t = 1;
        while (nxt[0] < 2 || nxt[1] < 2) begin
            s = (nxt[turn] < 2) ? turn : 1 - turn;
            for (int j = 0; j < lens[s][nxt[s]]; j++) begin
                e_src.push_back(s);
                e_dat.push_back(bpool[s][pos[s]]);
                e_step.push_back(t);
                pos[s]++;
                t++;
            end
            t++;
            nxt[s]++;
            turn = 1 - s;
        end
        n = e_src.size();
        run_until(n, 60, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL contention_count: got %0d bytes expected %0d", acc_src.size(), n);
        end
        for (int k = 0; k < n && k < acc_src.size(); k++) begin
            checks++;
            if (acc_src[k] != e_src[k] || acc_dat[k] !== e_dat[k] || acc_step[k] != e_step[k]
                || int'(acc_gid[k]) != e_src[k]) begin
                failures++;
                $display("FAIL contention_byte%0d: got src=%0d data=%h step=%0d gid=%b expected src=%0d data=%h step=%0d",
                         k, acc_src[k], acc_dat[k], acc_step[k], acc_gid[k], e_src[k], e_dat[k], e_step[k]);
            end
        end
    endtask

    task automatic test_lock();
        bit ok;
        bit released;
        int bad;
        int k;
        do_reset();
        push(0, 0,  1'b0, 8'h30);
        push(0, 50, 1'b0, 8'h31);
        push(0, 0,  1'b1, 8'h32);
        push(1, 0,  1'b1, 8'h40);
        released = 1'b0; bad = 0; k = 0;
        while (!released && k < 150) begin
            step();
            k++;
            if (acc_src.size() > 0 && acc_last[acc_src.size()-1]) released = 1'b1;
            if (s_rdy[1] !== 1'b0) bad++;
            if (stepn > 1 && s_busy !== 1'b1) bad++;
        end
        run_until(4, 20, ok);
        checks++;
        if (bad != 0 || !released) begin
            failures++; $display("FAIL lock_hold: got %0d bad cycles released=%b expected 0,1", bad, released);
        end
        checks++;
        if (!ok || acc_src[0] != 0 || acc_src[1] != 0 || acc_src[2] != 0 || acc_src[3] != 1
            || acc_dat[3] !== 8'h40) begin
            failures++; $display("FAIL lock_order: got %0d bytes last=%h expected 4 ending 40 from req1", acc_src.size(), acc_dat[3]);
        end
        checks++;
        if (acc_step[1] - acc_step[0] != 51 || evt_steps.size() != 0) begin
            failures++; $display("FAIL lock_pause: got gap=%0d evts=%0d expected 51,0", acc_step[1] - acc_step[0], evt_steps.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] a, b, c;
        bit         ok;
        int         exp_evt;
        sel_b = 1'b1;
        do_reset();
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        push(0, 0,  1'b0, a);
        push(0, 40, 1'b1, b);
        push(1, 0,  1'b1, c);
        run_until(3, 100, ok);
        repeat (3) step();
        exp_evt = acc_step[0] + 1 + TO_B;
        checks++;
        if (evt_steps.size() != 1 || evt_steps[0] != exp_evt) begin
            failures++; $display("FAIL timeout_evt: got %0d pulses first=%0d expected 1 at %0d",
                                 evt_steps.size(), evt_steps.size() > 0 ? evt_steps[0] : -1, exp_evt);
        end
        checks++;
        if (!ok || acc_src[1] != 1 || acc_dat[1] !== c || acc_step[1] != exp_evt + 1 || acc_gid[1] !== 1'b1) begin
            failures++; $display("FAIL timeout_regrant: got src=%0d data=%h step=%0d expected 1,%h,%0d",
                                 acc_src[1], acc_dat[1], acc_step[1], c, exp_evt + 1);
        end
        checks++;
        if (acc_dat[0] !== a || acc_dat[2] !== b || acc_src[2] != 0) begin
            failures++; $display("FAIL timeout_data: got %h,%h expected %h,%h", acc_dat[0], acc_dat[2], a, b);
        end
        sel_b = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        do_reset();
        rdy_pct = 0;
        push(0, 0, 1'b0, 8'h55);
        push(0, 0, 1'b1, 8'h56);
        step();
        bad = 0;
        for (int k = 0; k < 2340; k++) begin
            step();
            if (s_txv !== 1'b1 || s_txd !== 8'h55 || s_evt !== 1'b0 || s_busy !== 1'b1) bad++;
        end
        rdy_pct = 100;
        run_until(2, 10, ok);
        checks++;
        if (bad != 0 || evt_steps.size() != 0) begin
            failures++; $display("FAIL backpressure_stall: got %0d bad cycles %0d evts expected 0,0", bad, evt_steps.size());
        end
        checks++;
        if (!ok || acc_dat[0] !== 8'h55 || acc_dat[1] !== 8'h56 || acc_step[0] != 2341) begin
            failures++; $display("FAIL backpressure_accept: got %h,%h at %0d expected 55,56 at 2341",
                                 acc_dat[0], acc_dat[1], acc_step[0]);
        end
    endtask

    task automatic test_random();
        logic [8:0] ex0[$];
        logic [8:0] ex1[$];
        logic [8:0] e;
        int         total, len, bad_atom, bad_rr, bad_gid;
        bit         ok;
        do_reset();
        rdy_pct = 60;
        total = 0;
        for (int r = 0; r < NR; r++) begin
            for (int m = 0; m < 6; m++) begin
                len = int'($urandom_range(1, 4));
                for (int j = 0; j < len; j++) begin
                    logic [7:0] d;
                    int         gap;
                    d   = 8'($urandom);
                    gap = (j == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 3));
                    push(r, gap, j == len - 1, d);
                    if (r == 0) ex0.push_back({j == len - 1, d});
                    else        ex1.push_back({j == len - 1, d});
                    total++;
                end
            end
        end
        run_until(total, 3000, ok);
        repeat (2) step();
        checks++;
        if (!ok || acc_src.size() != total) begin
            failures++; $display("FAIL random_count: got %0d bytes expected %0d", acc_src.size(), total);
        end
        bad_atom = 0; bad_rr = 0; bad_gid = 0;
        for (int k = 0; k < acc_src.size(); k++) begin
            e = 9'h1FF;
            if (acc_src[k] == 0 && ex0.size() > 0) e = ex0.pop_front();
            if (acc_src[k] == 1 && ex1.size() > 0) e = ex1.pop_front();
            checks++;
            if ({acc_last[k], acc_dat[k]} !== e) begin
                failures++; $display("FAIL random_byte%0d: got src=%0d last=%b data=%h expected last=%b data=%h",
                                     k, acc_src[k], acc_last[k], acc_dat[k], e[8], e[7:0]);
            end
            if (int'(acc_gid[k]) != acc_src[k]) bad_gid++;
            if (k > 0 && !acc_last[k-1] && acc_src[k] != acc_src[k-1]) bad_atom++;
            if (k > 0 && acc_last[k-1] && acc_oth[k-1] && acc_src[k] == acc_src[k-1]) bad_rr++;
        end
        checks++;
        if (bad_atom != 0 || bad_rr != 0 || bad_gid != 0) begin
            failures++; $display("FAIL random_order: got atom=%0d rr=%0d gid=%0d violations expected 0", bad_atom, bad_rr, bad_gid);
        end
        checks++;
        if (inv_bad != 0 || evt_steps.size() != 0) begin
            failures++; $display("FAIL random_invariants: got %0d bad cycles %0d evts expected 0,0", inv_bad, evt_steps.size());
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_backpressure();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
